// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use, redirect squash,
// data-memory freeze, plus saturating stall/flush counters and a timeout flag.
module pipeline_hazard_controller #(
  parameter int CORE         = 0,
  parameter int DMEM_TIMEOUT = 256,
  parameter int COUNT_BITS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_memRead,
  input  logic                  ex_redirect,
  input  logic                  mem_access,
  input  logic                  d_valid,
  input  logic                  report,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_bubble,
  output logic [1:0]            ctrl_state,
  output logic                  dmem_timeout,
  output logic [COUNT_BITS-1:0] stall_count,
  output logic [COUNT_BITS-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    DMEM_WAIT = 2'd2
  } state_e;

  localparam int WW = $clog2(DMEM_TIMEOUT + 2);
  localparam logic [WW-1:0] WMAX = WW'(DMEM_TIMEOUT);

  state_e                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  tout_q, tout_d;
  logic [COUNT_BITS-1:0] stall_q, stall_d;
  logic [COUNT_BITS-1:0] flush_q, flush_d;

  logic dstall, loaduse;
  logic freeze, run_eval, take;
  logic pc_s, ifid_s, ifid_f, idex_s, idex_f, exmem_s, wb_b;

  always_comb begin
    dstall  = mem_access && !d_valid;
    loaduse = ex_memRead && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    freeze   = 1'b0;
    run_eval = 1'b0;
    take     = 1'b0;
    ifid_f   = 1'b0;
    idex_f   = 1'b0;
    state_d  = state_q;
    pend_d   = pend_q;
    wait_d   = wait_q;
    unique case (state_q)
      RUN: begin
        if (dstall) begin
          freeze  = 1'b1;
          state_d = DMEM_WAIT;
          // redirect is accepted (and counted) now, replayed after the wait
          if (ex_redirect) begin
            pend_d = 1'b1;
            take   = 1'b1;
          end
        end else begin
          run_eval = 1'b1;
        end
      end
      FLUSH: begin
        if (dstall) begin
          freeze  = 1'b1;
          state_d = DMEM_WAIT;
          pend_d  = 1'b1;
        end else begin
          ifid_f  = 1'b1;
          state_d = RUN;
        end
      end
      DMEM_WAIT: begin
        if (dstall) begin
          freeze = 1'b1;
          if (wait_q != WMAX) wait_d = wait_q + 1'b1;
        end else begin
          wait_d = '0;
          if (pend_q) begin
            ifid_f  = 1'b1;
            pend_d  = 1'b0;
            state_d = FLUSH;
          end else begin
            state_d  = RUN;
            run_eval = 1'b1;
          end
        end
      end
      default: begin
        state_d = RUN;
        pend_d  = 1'b0;
      end
    endcase
    pc_s    = freeze;
    ifid_s  = freeze;
    idex_s  = freeze;
    exmem_s = freeze;
    wb_b    = freeze;
    if (run_eval) begin
      if (ex_redirect) begin
        ifid_f  = 1'b1;
        idex_f  = 1'b1;
        take    = 1'b1;
        state_d = FLUSH;
      end else if (loaduse) begin
        pc_s   = 1'b1;
        ifid_s = 1'b1;
        idex_f = 1'b1;
      end
    end
  end

  always_comb begin
    tout_d  = tout_q || (wait_d == WMAX);
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_s && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (take && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      wait_q  <= '0;
      tout_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      tout_q  <= tout_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign pc_stall      = reset & pc_s;
  assign if_id_stall   = reset & ifid_s;
  assign if_id_flush   = reset & ifid_f;
  assign id_ex_stall   = reset & idex_s;
  assign id_ex_flush   = reset & idex_f;
  assign ex_mem_stall  = reset & exmem_s;
  assign mem_wb_bubble = reset & wb_b;
  assign ctrl_state    = state_q;
  assign dmem_timeout  = tout_q;
  assign stall_count   = stall_q;
  assign flush_count   = flush_q;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset && report)
      $display("[core %0d] stall_count=%0d flush_count=%0d dmem_timeout=%0b",
               CORE, stall_q, flush_q, tout_q);
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: single-cycle vector table
// from RUN plus multi-cycle redirect, dmem-wait, timeout and reset sequences.
module tb_pipeline_hazard_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_memRead, ex_redirect, mem_access, d_valid, report;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic       id_ex_flush, ex_mem_stall, mem_wb_bubble;
  logic [1:0] ctrl_state;
  logic       dmem_timeout;
  logic [3:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(
    .CORE(0), .DMEM_TIMEOUT(8), .COUNT_BITS(4)
  ) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memRead(ex_memRead),
    .ex_redirect(ex_redirect), .mem_access(mem_access),
    .d_valid(d_valid), .report(report),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .ctrl_state(ctrl_state),
    .dmem_timeout(dmem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // {pc, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, bubble}
  wire [6:0] outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                     id_ex_flush, ex_mem_stall, mem_wb_bubble};

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_RED  = 7'b0010100;
  localparam logic [6:0] O_IFF  = 7'b0010000;
  localparam logic [6:0] O_FRZ  = 7'b1101011;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, rdr, ma, dv;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_memRead = 0; ex_redirect = 0;
    mem_access = 0; d_valid = 0; report = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // EX holds a bubble during FLUSH, so a redirect there is illegal
  always @(negedge clock) begin
    if (reset && ctrl_state == 2'd1 && ex_redirect) begin
      fails++;
      $display("FAIL redirect_in_flush: ex_redirect=1 state=%0d", ctrl_state);
    end
  end

  initial begin
    vt[0]  = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE};
    vt[1]  = '{"lu_rs2",      0, 5, 0, 1, 5, 1, 0, 0, 0, O_LU};
    vt[2]  = '{"lu_rd0",      0, 0, 0, 1, 0, 1, 0, 0, 0, O_NONE};
    vt[3]  = '{"lu_rs1",      7, 0, 1, 0, 7, 1, 0, 0, 0, O_LU};
    vt[4]  = '{"lu_rs1_nuse", 7, 0, 0, 1, 7, 1, 0, 0, 0, O_NONE};
    vt[5]  = '{"lu_noload",   9, 9, 1, 1, 9, 0, 0, 0, 0, O_NONE};
    vt[6]  = '{"redirect",    0, 0, 0, 0, 0, 0, 1, 0, 0, O_RED};
    vt[7]  = '{"redir_lu",    3, 0, 1, 0, 3, 1, 1, 0, 0, O_RED};
    vt[8]  = '{"dstall",      0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ};
    vt[9]  = '{"mem_done",    0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE};
    vt[10] = '{"dstall_red",  0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ};
    vt[11] = '{"dstall_lu",   4, 4, 1, 1, 4, 1, 0, 1, 0, O_FRZ};

    idle();
    reset = 1'b0;
    mem_access = 1'b1;
    ex_redirect = 1'b1;
    #12;
    check("rst_outs", 32'(outs), 32'(O_NONE));
    check("rst_state", 32'(ctrl_state), 0);
    check("rst_cnts", {stall_count, flush_count, 3'b0, dmem_timeout}, 0);
    idle();
    @(posedge clock);
    #1;
    reset = 1'b1;

    foreach (vt[i]) begin
      do_reset();
      id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2;
      id_use_rs1 = vt[i].u1; id_use_rs2 = vt[i].u2;
      ex_rd = vt[i].rd; ex_memRead = vt[i].mr;
      ex_redirect = vt[i].rdr; mem_access = vt[i].ma;
      d_valid = vt[i].dv;
      @(negedge clock);
      check({"vec_", vt[i].name}, 32'(outs), 32'(vt[i].exp));
      idle();
      step();
    end

    // load-use: one stall cycle, bubble then clears ex_memRead
    do_reset();
    ex_memRead = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    @(negedge clock);
    check("lu_c0", 32'(outs), 32'(O_LU));
    step();
    ex_memRead = 0;
    @(negedge clock);
    check("lu_c1", 32'(outs), 32'(O_NONE));
    check("lu_stall_count", 32'(stall_count), 1);
    idle();
    step();

    // redirect: two-cycle squash
    do_reset();
    ex_redirect = 1;
    @(negedge clock);
    check("red_c0", 32'(outs), 32'(O_RED));
    step();
    ex_redirect = 0;
    @(negedge clock);
    check("red_c1", 32'(outs), 32'(O_IFF));
    check("red_c1_state", 32'(ctrl_state), 1);
    step();
    @(negedge clock);
    check("red_c2_state", 32'(ctrl_state), 0);
    check("red_c2_outs", 32'(outs), 32'(O_NONE));
    check("red_flush_count", 32'(flush_count), 1);
    step();

    // dmem wait: 4 frozen cycles, release in the d_valid cycle
    do_reset();
    mem_access = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check($sformatf("dw_frz%0d", c), 32'(outs), 32'(O_FRZ));
      check($sformatf("dw_st%0d", c), 32'(ctrl_state), (c == 0) ? 0 : 2);
      step();
    end
    d_valid = 1;
    @(negedge clock);
    check("dw_release", 32'(outs), 32'(O_NONE));
    step();
    idle();
    @(negedge clock);
    check("dw_state_run", 32'(ctrl_state), 0);
    check("dw_stall_count", 32'(stall_count), 4);
    step();

    // dstall + redirect together: freeze, then a single squash
    do_reset();
    mem_access = 1; ex_redirect = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("sim_frz%0d", c), 32'(outs), 32'(O_FRZ));
      step();
    end
    d_valid = 1;
    @(negedge clock);
    check("sim_dv", 32'(outs), 32'(O_IFF));
    step();
    idle();
    @(negedge clock);
    check("sim_flush_state", 32'(ctrl_state), 1);
    check("sim_flush_outs", 32'(outs), 32'(O_IFF));
    step();
    @(negedge clock);
    check("sim_run_state", 32'(ctrl_state), 0);
    check("sim_flush_count", 32'(flush_count), 1);
    step();

    // timeout: 8 cycles in DMEM_WAIT sets the sticky flag
    do_reset();
    mem_access = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 8 || c == 9)
        check($sformatf("to_c%0d", c), 32'(dmem_timeout), (c == 9) ? 1 : 0);
      step();
    end
    d_valid = 1;
    step();
    idle();
    report = 1;
    step();
    report = 0;
    @(negedge clock);
    check("to_sticky", 32'(dmem_timeout), 1);
    check("to_state_run", 32'(ctrl_state), 0);
    step();
    do_reset();
    @(negedge clock);
    check("to_cleared", 32'(dmem_timeout), 0);
    step();

    // saturation at 15, then async reset mid-wait with a pending flush
    mem_access = 1;
    for (int c = 0; c < 20; c++) step();
    d_valid = 1;
    @(negedge clock);
    check("sat_stall_count", 32'(stall_count), 15);
    step();
    idle();
    mem_access = 1; ex_redirect = 1;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_outs", 32'(outs), 32'(O_NONE));
    check("rstmid_state", 32'(ctrl_state), 0);
    check("rstmid_cnts", {stall_count, flush_count}, 0);
    check("rstmid_tout", 32'(dmem_timeout), 0);
    idle();
    #1;
    reset = 1'b1;
    step();
    @(negedge clock);
    check("rstmid_no_pend", {30'(outs), ctrl_state}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

endmodule
